// File: rtl/avalon_io_byte_responder_pkg.sv
// Shared types, constants and lane helpers for the Avalon IO byte responder.
package avalon_io_byte_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GAP    = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int          NUM_LANES       = 4;
   localparam logic [7:0]  FLOAT_BYTE      = 8'hFF;
   localparam logic [31:0] FLOAT_WORD      = 32'hFFFF_FFFF;
   localparam int unsigned DEFAULT_TIMEOUT = 15;

   // Extract one byte lane from a 32-bit word.
   function automatic logic [7:0] get_lane_byte(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

   // Replace one byte lane of a 32-bit word.
   function automatic logic [31:0] put_lane_byte(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [7:0] data);
      logic [31:0] result;
      result = word;
      result[{lane, 3'b000} +: 8] = data;
      return result;
   endfunction

endpackage

// File: rtl/avalon_io_byte_responder_io_lane_select.sv
// Priority picker: lowest enabled lane at or above start_lane, with a
// flag raised when no enabled lane remains in that range.
module io_lane_select
   import avalon_io_byte_responder_pkg::*;
(
   input  logic [3:0] byteenable,
   input  logic [2:0] start_lane,
   output logic [1:0] next_lane,
   output logic       none_left
);

   logic cand_s;

   // Scan from the top lane down so the lowest qualifying lane wins last.
   always_comb begin
      next_lane = 2'd0;
      none_left = 1'b1;
      cand_s    = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         cand_s    = byteenable[i] && (3'(i) >= start_lane);
         next_lane = cand_s ? 2'(i) : next_lane;
         none_left = cand_s ? 1'b0 : none_left;
      end
   end

endmodule

// File: rtl/avalon_io_byte_responder.sv
// Avalon-MM IO responder: splits each 32-bit access into ascending
// single-byte accesses on an 8-bit legacy port with per-byte timeout,
// assembling read bytes (timed-out or disabled lanes float to 8'hFF).
module avalon_io_byte_responder
   import avalon_io_byte_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] io_address,
   input  logic [3:0]  io_byteenable,
   input  logic        io_read,
   input  logic        io_write,
   input  logic [31:0] io_writedata,
   output logic        io_waitrequest,
   output logic [31:0] io_readdata,
   output logic        io_readdatavalid,
   output logic [15:0] dev_address,
   output logic        dev_read,
   output logic        dev_write,
   output logic [7:0]  dev_writedata,
   input  logic [7:0]  dev_readdata,
   input  logic        dev_ack,
   output logic        dev_timeout
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

   state_e      state_q, state_d;
   logic [13:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        is_write_q, is_write_d;
   logic [1:0]  lane_q, lane_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic [31:0] word_q, word_d;
   logic        dev_read_q, dev_read_d;
   logic        dev_write_q, dev_write_d;
   logic [15:0] dev_address_q, dev_address_d;
   logic [7:0]  dev_writedata_q, dev_writedata_d;
   logic [31:0] io_readdata_q, io_readdata_d;
   logic        io_readdatavalid_q, io_readdatavalid_d;
   logic        dev_timeout_q, dev_timeout_d;

   logic [3:0]  sel_be_s;
   logic [2:0]  sel_start_s;
   logic [1:0]  sel_lane_s;
   logic        sel_none_s;
   logic [31:0] word_next_s;
   logic        unused_addr_s;

   // Word address low bits carry no information.
   assign unused_addr_s = ^io_address[1:0];

   assign io_waitrequest   = (state_q != ST_IDLE);
   assign io_readdata      = io_readdata_q;
   assign io_readdatavalid = io_readdatavalid_q;
   assign dev_address      = dev_address_q;
   assign dev_read         = dev_read_q;
   assign dev_write        = dev_write_q;
   assign dev_writedata    = dev_writedata_q;
   assign dev_timeout      = dev_timeout_q;

   // Picker inputs: the incoming command while idle, else the lanes above the current one.
   always_comb begin
      if (state_q == ST_IDLE) begin
         sel_be_s    = io_byteenable;
         sel_start_s = 3'd0;
      end else begin
         sel_be_s    = be_q;
         sel_start_s = {1'b0, lane_q} + 3'd1;
      end
   end

   io_lane_select u_lane_select (
      .byteenable (sel_be_s),
      .start_lane (sel_start_s),
      .next_lane  (sel_lane_s),
      .none_left  (sel_none_s)
   );

   // Next-state and next-output logic for the byte sequencer.
   always_comb begin
      state_d            = state_q;
      addr_d             = addr_q;
      be_d               = be_q;
      wdata_d            = wdata_q;
      is_write_d         = is_write_q;
      lane_d             = lane_q;
      tcnt_d             = tcnt_q;
      word_d             = word_q;
      word_next_s        = word_q;
      dev_read_d         = 1'b0;
      dev_write_d        = 1'b0;
      dev_address_d      = dev_address_q;
      dev_writedata_d    = dev_writedata_q;
      io_readdata_d      = io_readdata_q;
      io_readdatavalid_d = 1'b0;
      dev_timeout_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (io_read || io_write) begin
               // Write wins when both requests are raised together.
               is_write_d = io_write;
               addr_d     = io_address[15:2];
               be_d       = io_byteenable;
               wdata_d    = io_writedata;
               word_d     = FLOAT_WORD;
               if (sel_none_s) begin
                  if (io_write) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d            = ST_RESP;
                     io_readdata_d      = FLOAT_WORD;
                     io_readdatavalid_d = 1'b1;
                  end
               end else begin
                  state_d         = ST_STROBE;
                  lane_d          = sel_lane_s;
                  tcnt_d          = 8'd0;
                  dev_read_d      = ~io_write;
                  dev_write_d     = io_write;
                  dev_address_d   = {io_address[15:2], sel_lane_s};
                  dev_writedata_d = get_lane_byte(io_writedata, sel_lane_s);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_STROBE: begin
            if (dev_ack || (tcnt_q == TMO_LAST)) begin
               // Ack has priority over a timeout landing in the same cycle.
               dev_timeout_d = ~dev_ack;
               if (is_write_q) begin
                  word_next_s = word_q;
               end else begin
                  word_next_s = put_lane_byte(word_q, lane_q, dev_ack ? dev_readdata : FLOAT_BYTE);
               end
               word_d = word_next_s;
               if (!sel_none_s) begin
                  state_d = ST_GAP;
               end else if (is_write_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d            = ST_RESP;
                  io_readdata_d      = word_next_s;
                  io_readdatavalid_d = 1'b1;
               end
            end else begin
               tcnt_d      = (tcnt_q == 8'hFF) ? tcnt_q : (tcnt_q + 8'd1);
               dev_read_d  = dev_read_q;
               dev_write_d = dev_write_q;
            end
         end

         ST_GAP: begin
            state_d         = ST_STROBE;
            lane_d          = sel_lane_s;
            tcnt_d          = 8'd0;
            dev_read_d      = ~is_write_q;
            dev_write_d     = is_write_q;
            dev_address_d   = {addr_q, sel_lane_s};
            dev_writedata_d = get_lane_byte(wdata_q, sel_lane_s);
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q            <= ST_IDLE;
         addr_q             <= 14'd0;
         be_q               <= 4'd0;
         wdata_q            <= 32'd0;
         is_write_q         <= 1'b0;
         lane_q             <= 2'd0;
         tcnt_q             <= 8'd0;
         word_q             <= 32'd0;
         dev_read_q         <= 1'b0;
         dev_write_q        <= 1'b0;
         dev_address_q      <= 16'd0;
         dev_writedata_q    <= 8'd0;
         io_readdata_q      <= 32'd0;
         io_readdatavalid_q <= 1'b0;
         dev_timeout_q      <= 1'b0;
      end else begin
         state_q            <= state_d;
         addr_q             <= addr_d;
         be_q               <= be_d;
         wdata_q            <= wdata_d;
         is_write_q         <= is_write_d;
         lane_q             <= lane_d;
         tcnt_q             <= tcnt_d;
         word_q             <= word_d;
         dev_read_q         <= dev_read_d;
         dev_write_q        <= dev_write_d;
         dev_address_q      <= dev_address_d;
         dev_writedata_q    <= dev_writedata_d;
         io_readdata_q      <= io_readdata_d;
         io_readdatavalid_q <= io_readdatavalid_d;
         dev_timeout_q      <= dev_timeout_d;
      end
   end

endmodule

// File: tb/tb_avalon_io_byte_responder.sv
// Scoreboard bench: stimulus pushes expected byte accesses and read words,
// a device model and a read monitor pop and compare independently.
module tb_avalon_io_byte_responder;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] io_address = 16'd0;
   logic [3:0]  io_byteenable = 4'd0;
   logic        io_read = 1'b0;
   logic        io_write = 1'b0;
   logic [31:0] io_writedata = 32'd0;
   logic        io_waitrequest;
   logic [31:0] io_readdata;
   logic        io_readdatavalid;
   logic [15:0] dev_address;
   logic        dev_read;
   logic        dev_write;
   logic [7:0]  dev_writedata;
   logic [7:0]  dev_readdata = 8'd0;
   logic        dev_ack = 1'b0;
   logic        dev_timeout;

   typedef struct {
      logic [15:0] addr;
      bit          wr;
      logic [7:0]  wdata;
      bit          ack;
      int          k;
      logic [7:0]  rdata;
   } dev_exp_t;

   typedef struct {
      logic [31:0] data;
      int unsigned cycle;
   } rd_exp_t;

   dev_exp_t    dev_q[$];
   rd_exp_t     rd_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   avalon_io_byte_responder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .io_address       (io_address),
      .io_byteenable    (io_byteenable),
      .io_read          (io_read),
      .io_write         (io_write),
      .io_writedata     (io_writedata),
      .io_waitrequest   (io_waitrequest),
      .io_readdata      (io_readdata),
      .io_readdatavalid (io_readdatavalid),
      .dev_address      (dev_address),
      .dev_read         (dev_read),
      .dev_write        (dev_write),
      .dev_writedata    (dev_writedata),
      .dev_readdata     (dev_readdata),
      .dev_ack          (dev_ack),
      .dev_timeout      (dev_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one command at a negedge with the DUT idle; returns once idle again.
   task automatic issue(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                        input bit rd, input bit wr, input logic [3:0] ack_mask,
                        input logic [7:0] kvec, input logic [31:0] rbytes);
      dev_exp_t    e;
      rd_exp_t     r;
      logic [31:0] word;
      logic [15:0] first_addr;
      int          base;
      int          n;
      int          budget;
      int unsigned c0;
      word       = 32'hFFFF_FFFF;
      base       = 0;
      n          = 0;
      first_addr = 16'd0;
      for (int l = 0; l < 4; l++) begin
         if (be[l]) begin
            e.addr  = {addr[15:2], 2'(l)};
            e.wr    = wr;
            e.wdata = wdata[8*l +: 8];
            e.ack   = ack_mask[l];
            e.k     = int'(kvec[2*l +: 2]);
            e.rdata = rbytes[8*l +: 8];
            dev_q.push_back(e);
            if (n == 0) first_addr = e.addr;
            base += e.ack ? (1 + e.k) : TMO;
            if (!wr) word[8*l +: 8] = e.ack ? e.rdata : 8'hFF;
            n++;
         end
      end
      base = (n == 0) ? 1 : (base + (n - 1) + 1);
      c0 = cyc;
      io_address    = addr;
      io_byteenable = be;
      io_writedata  = wdata;
      io_read       = rd;
      io_write      = wr;
      if (!wr) begin
         r.data  = word;
         r.cycle = c0 + 32'(base);
         rd_q.push_back(r);
      end
      @(negedge clk);
      io_read  = 1'b0;
      io_write = 1'b0;
      if (n != 0) begin
         check("first_strobe", {30'd0, dev_write, dev_read}, wr ? 32'd2 : 32'd1);
         check("first_address", {16'd0, dev_address}, {16'd0, first_addr});
      end else begin
         check("no_strobe", {30'd0, dev_write, dev_read}, 32'd0);
      end
      budget = 0;
      while (io_waitrequest === 1'b1 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("idle_cycle", cyc, c0 + 32'(base) + (wr ? 32'd0 : 32'd1));
   endtask

   // Legacy device model: validates each byte access and acks per plan.
   initial begin : device
      dev_exp_t cur;
      bit       serving;
      bit       gap_chk;
      bit       tmo_pend;
      bit       strobe;
      int       cnt;
      serving  = 1'b0;
      gap_chk  = 1'b0;
      tmo_pend = 1'b0;
      cnt      = 0;
      forever begin
         @(negedge clk);
         dev_ack = 1'b0;
         if (rst_n !== 1'b1) begin
            serving  = 1'b0;
            gap_chk  = 1'b0;
            tmo_pend = 1'b0;
         end else begin
            strobe = (dev_read === 1'b1) || (dev_write === 1'b1);
            if (tmo_pend || dev_timeout === 1'b1) check("dev_timeout", {31'd0, dev_timeout}, {31'd0, tmo_pend});
            tmo_pend = 1'b0;
            if (gap_chk) check("strobe_low_after_byte", {31'd0, strobe}, 32'd0);
            gap_chk = 1'b0;
            if (serving) begin
               cnt++;
               check("strobe_held", {31'd0, strobe}, 32'd1);
               check("held_address", {16'd0, dev_address}, {16'd0, cur.addr});
            end else if (strobe) begin
               if (dev_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe: got address %h expected no access", dev_address);
               end else begin
                  cur = dev_q.pop_front();
                  check("dev_address", {16'd0, dev_address}, {16'd0, cur.addr});
                  check("dev_dir", {30'd0, dev_write, dev_read}, cur.wr ? 32'd2 : 32'd1);
                  if (cur.wr) check("dev_writedata", {24'd0, dev_writedata}, {24'd0, cur.wdata});
                  serving = 1'b1;
                  cnt     = 1;
               end
            end
            if (serving) begin
               if (cur.ack && cnt == cur.k + 1) begin
                  dev_ack      = 1'b1;
                  dev_readdata = cur.rdata;
                  serving      = 1'b0;
                  gap_chk      = 1'b1;
               end else if (!cur.ack && cnt == TMO) begin
                  serving  = 1'b0;
                  gap_chk  = 1'b1;
                  tmo_pend = 1'b1;
               end
            end else if (!strobe && $urandom_range(0, 3) == 0) begin
               dev_ack      = 1'b1;
               dev_readdata = 8'($urandom);
            end
         end
      end
   end

   // Read monitor: every io_readdatavalid pulse must match the next expected word.
   initial begin : monitor
      rd_exp_t r;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && io_readdatavalid === 1'b1) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_readdatavalid: got valid=1 data %h expected no response", io_readdata);
            end else begin
               r = rd_q.pop_front();
               check("readdata", io_readdata, r.data);
               check("readdata_cycle", cyc, r.cycle);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [3:0] be;
      bit         rd;
      bit         wr;
      repeat (3) @(negedge clk);
      check("rst_readdata", io_readdata, 32'd0);
      check("rst_readdatavalid", {31'd0, io_readdatavalid}, 32'd0);
      check("rst_strobes", {30'd0, dev_write, dev_read}, 32'd0);
      check("rst_dev_address", {16'd0, dev_address}, 32'd0);
      check("rst_dev_writedata", {24'd0, dev_writedata}, 32'd0);
      check("rst_dev_timeout", {31'd0, dev_timeout}, 32'd0);
      check("rst_waitrequest", {31'd0, io_waitrequest}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-byte read, k=0.
      issue(16'h0060, 4'b0001, 32'd0, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0000_00A5);
      // Two-lane write, k=2 on both lanes.
      issue(16'h0388, 4'b0110, 32'h00BE_EF00, 1'b0, 1'b1, 4'hF, 8'b1010_1010, 32'd0);
      // Four-byte read, k=0 on every lane.
      issue(16'h1230, 4'b1111, 32'd0, 1'b0 | 1'b1, 1'b0, 4'hF, 8'h00, 32'h4433_2211);
      // Four-byte read with lane 2 timing out.
      issue(16'h2000, 4'b1111, 32'd0, 1'b1, 1'b0, 4'b1011, 8'($urandom), $urandom);
      // Read and write together: write wins.
      issue(16'h0404, 4'b1001, 32'hCAFE_F00D, 1'b1, 1'b1, 4'hF, 8'($urandom), $urandom);
      // Zero-enable read and write.
      issue(16'h0500, 4'b0000, 32'd0, 1'b1, 1'b0, 4'hF, 8'h00, 32'd0);
      issue(16'h0504, 4'b0000, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 8'h00, 32'd0);

      // Reset while lane 1 is strobing.
      dev_q.push_back('{addr: 16'h0100, wr: 1'b0, wdata: 8'h00, ack: 1'b1, k: 0, rdata: 8'h11});
      dev_q.push_back('{addr: 16'h0101, wr: 1'b0, wdata: 8'h00, ack: 1'b0, k: 0, rdata: 8'h22});
      io_address    = 16'h0100;
      io_byteenable = 4'b0011;
      io_read       = 1'b1;
      @(negedge clk);
      io_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_lane1_strobe", {16'd0, dev_address}, 32'h0000_0101);
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_strobes_drop", {30'd0, dev_write, dev_read}, 32'd0);
      check("reset_waitrequest", {31'd0, io_waitrequest}, 32'd0);
      check("reset_no_valid", {31'd0, io_readdatavalid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dev_q.delete();
      @(negedge clk);
      issue(16'h0100, 4'b0011, 32'd0, 1'b1, 1'b0, 4'hF, 8'b0000_0100, 32'h0000_7766);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         be = 4'($urandom);
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) rd = 1'b1;
         issue(16'($urandom), be, $urandom, rd, wr, 4'($urandom) | 4'($urandom),
               8'($urandom), $urandom);
      end

      repeat (5) @(negedge clk);
      check("dev_queue_drained", 32'(dev_q.size()), 32'd0);
      check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
